// File: rtl/matvec_pkg.sv
// Shared types and helpers for the matrix-vector engine: controller state
// encoding and a generic sign/zero extension used by the MAC lanes.
package matvec_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CALC,
        DONE
    } state_e;

    // Widest value the extension helper handles; callers cast the result down.
    localparam int EXT_W = 128;

    // Extend the low w bits of v to EXT_W bits, replicating bit w-1 when is_signed.
    function automatic logic [EXT_W-1:0] extend_val(
        input logic [EXT_W-1:0] v,
        input int               w,
        input logic             is_signed
    );
        logic [EXT_W-1:0] r;
        logic             fill;
        fill = is_signed & v[7'(w - 1)];
        for (int i = 0; i < EXT_W; i++) begin
            r[7'(i)] = (i < w) ? v[7'(i)] : fill;
        end
        return r;
    endfunction

endpackage

// File: rtl/matvec_engine_mac_lane.sv
// One multiply-accumulate lane: acc += ext(a*b), wrapping at ACC_WIDTH bits.
// clr takes priority over en so a fresh run always starts from zero.
module mac_lane
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [ACC_WIDTH-1:0]  acc_o
);

    localparam int PW = 2 * DATA_WIDTH;

    logic [PW-1:0]        prod;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;

    generate
        if (SIGNED != 0) begin : g_signed
            assign prod = PW'($signed(a_i)) * PW'($signed(b_i));
        end else begin : g_unsigned
            assign prod = PW'(a_i) * PW'(b_i);
        end
    endgenerate

    assign prod_ext = ACC_WIDTH'(extend_val(EXT_W'(prod), PW, SIGNED != 0));

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + prod_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matvec_engine.sv
// Matrix-vector engine: fetches B then the ROWS rows of A over an Avalon-MM
// pipelined read master, then runs ROWS MAC lanes for COLS cycles.
module matvec_engine
    import matvec_pkg::*;
#(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 24,
    parameter int ADDR_WIDTH = 32,
    parameter int SIGNED     = 0,
    localparam int SEL_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int WORD_W    = COLS * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  accumulate,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic [WORD_W-1:0]     avm_readdata,
    input  logic                  avm_readdatavalid,
    input  logic                  avm_waitrequest,
    input  logic [SEL_W-1:0]      res_sel,
    output logic [ACC_WIDTH-1:0]  res_data
);

    localparam int NREQ  = ROWS + 1;
    localparam int CNT_W = $clog2(NREQ + 1);
    localparam int K_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LSB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    state_e                 state_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic                   rd_q;
    logic                   busy_q;
    logic                   done_q;
    logic [CNT_W-1:0]       req_cnt_q;
    logic [CNT_W-1:0]       rsp_cnt_q;
    logic [K_W-1:0]         k_q;
    logic [WORD_W-1:0]      b_buf_q;
    logic [WORD_W-1:0]      a_buf_q [ROWS];

    logic [SEL_W-1:0]       a_row_idx;
    logic [LSB_W-1:0]       elem_lsb;
    logic [DATA_WIDTH-1:0]  b_elem;
    logic                   mac_en;
    logic                   mac_clr;
    logic [ACC_WIDTH-1:0]   acc [ROWS];

    // Response 0 is B; response r+1 lands in A row r.
    assign a_row_idx = SEL_W'(rsp_cnt_q - CNT_W'(1));
    // Element 0 sits in the MSBs of each word.
    assign elem_lsb  = LSB_W'((COLS - 1 - int'(k_q)) * DATA_WIDTH);
    assign b_elem    = b_buf_q[elem_lsb +: DATA_WIDTH];
    assign mac_en    = (state_q == CALC);
    // accumulate only matters at the accepted start, so it drives the clear directly.
    assign mac_clr   = (state_q == IDLE) && start && !accumulate;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
            k_q       <= '0;
            b_buf_q   <= '0;
            for (int r = 0; r < ROWS; r++) begin
                a_buf_q[r] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        busy_q    <= 1'b1;
                        rd_q      <= 1'b1;
                        addr_q    <= base_addr;
                        req_cnt_q <= '0;
                        rsp_cnt_q <= '0;
                        k_q       <= '0;
                    end
                end
                FETCH: begin
                    if (rd_q && !avm_waitrequest) begin
                        addr_q    <= addr_q + 1'b1;
                        req_cnt_q <= req_cnt_q + 1'b1;
                        if (req_cnt_q == CNT_W'(ROWS)) begin
                            rd_q <= 1'b0;
                        end
                    end
                    if (avm_readdatavalid && (rsp_cnt_q < CNT_W'(NREQ))) begin
                        rsp_cnt_q <= rsp_cnt_q + 1'b1;
                        if (rsp_cnt_q == '0) begin
                            b_buf_q <= avm_readdata;
                        end else begin
                            a_buf_q[a_row_idx] <= avm_readdata;
                        end
                        if (rsp_cnt_q == CNT_W'(ROWS)) begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    k_q <= k_q + 1'b1;
                    if (k_q == K_W'(COLS - 1)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < ROWS; gi++) begin : g_lane
            mac_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .ACC_WIDTH  (ACC_WIDTH),
                .SIGNED     (SIGNED)
            ) u_lane (
                .clk   (clk),
                .rst_n (rst_n),
                .en_i  (mac_en),
                .clr_i (mac_clr),
                .a_i   (a_buf_q[gi][elem_lsb +: DATA_WIDTH]),
                .b_i   (b_elem),
                .acc_o (acc[gi])
            );
        end
    endgenerate

    assign res_data    = (int'(res_sel) < ROWS) ? acc[res_sel] : '0;
    assign busy        = busy_q;
    assign done        = done_q;
    assign avm_read    = rd_q;
    assign avm_address = addr_q;

endmodule

// File: tb/tb_matvec_engine.sv
// Bench: three engines (unsigned/24, signed/24, unsigned/16) share one memory
// model; directed table, hand-written corner sequences, then random runs.
module tb_matvec_engine;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int DW   = 8;
    localparam int AW   = 32;
    localparam int WW   = COLS * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          accumulate = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [WW-1:0] avm_readdata = '0;
    logic          avm_readdatavalid = 1'b0;
    logic          avm_waitrequest = 1'b0;
    logic [2:0]    res_sel = '0;

    logic          busy_v [3];
    logic          done_v [3];
    logic          rd_v   [3];
    logic [AW-1:0] addr_v [3];
    logic [23:0]   res_u;
    logic [23:0]   res_s;
    logic [15:0]   res_16;

    matvec_engine #(.SIGNED(0), .ACC_WIDTH(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
        .base_addr(base_addr), .busy(busy_v[0]), .done(done_v[0]),
        .avm_address(addr_v[0]), .avm_read(rd_v[0]), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .res_sel(res_sel), .res_data(res_u));

    matvec_engine #(.SIGNED(1), .ACC_WIDTH(24)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
        .base_addr(base_addr), .busy(busy_v[1]), .done(done_v[1]),
        .avm_address(addr_v[1]), .avm_read(rd_v[1]), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .res_sel(res_sel), .res_data(res_s));

    matvec_engine #(.SIGNED(0), .ACC_WIDTH(16)) u_dut_16 (
        .clk(clk), .rst_n(rst_n), .start(start), .accumulate(accumulate),
        .base_addr(base_addr), .busy(busy_v[2]), .done(done_v[2]),
        .avm_address(addr_v[2]), .avm_read(rd_v[2]), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
        .res_sel(res_sel), .res_data(res_16));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model (slave side) ----------------
    typedef struct {
        logic [WW-1:0] data;
        int            due;
    } rsp_t;

    logic [WW-1:0] mem [16];
    rsp_t          pend [$];
    logic [AW-1:0] acc_addr_q [$];
    int            lat = 1;
    bit            stall_en = 0;
    int            stall_left = 0;
    int            last_due = -1;
    int            done_cnt = 0;
    bit            prev_stall = 0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        rsp_t head;
        bit   wr;
        if (prev_stall && rst_n)
            chk("addr_hold", {31'b0, rd_v[0], addr_v[0]}, {31'b0, 1'b1, prev_addr});
        if (done_v[0]) done_cnt++;
        avm_readdatavalid = 1'b0;
        avm_readdata = {$urandom, $urandom};
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            head = pend.pop_front();
            avm_readdata = head.data;
            avm_readdatavalid = 1'b1;
        end
        if (stall_left > 0) begin
            wr = 1;
            stall_left--;
        end else if (stall_en && $urandom_range(0, 3) == 0) begin
            wr = 1;
            stall_left = $urandom_range(0, 7);
        end else begin
            wr = 0;
        end
        avm_waitrequest = wr;
        prev_stall = rd_v[0] && wr && rst_n;
        prev_addr = addr_v[0];
        if (rd_v[0] && !wr && rst_n) begin
            acc_addr_q.push_back(addr_v[0]);
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{data: mem[addr_v[0][3:0]], due: last_due});
        end
    end

    // ---------------- reference model ----------------
    longint exp_u [ROWS];
    longint exp_s [ROWS];
    longint exp_16 [ROWS];

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++) begin
            exp_u[r] = 0;
            exp_s[r] = 0;
            exp_16[r] = 0;
        end
    endfunction

    // C[r] = sum_k A[r][k]*B[k], element 0 in the word MSBs, wrapped per width.
    function automatic void model_run(input logic acc_in, input logic [AW-1:0] base);
        logic [WW-1:0] bw;
        logic [WW-1:0] aw;
        logic [7:0]    ea;
        logic [7:0]    eb;
        longint        su;
        longint        ss;
        bw = mem[4'(base)];
        for (int r = 0; r < ROWS; r++) begin
            aw = mem[4'(base + 32'(r) + 32'd1)];
            su = 0;
            ss = 0;
            for (int k = 0; k < COLS; k++) begin
                ea = aw[(COLS - 1 - k) * DW +: DW];
                eb = bw[(COLS - 1 - k) * DW +: DW];
                su += longint'(ea) * longint'(eb);
                ss += longint'($signed(ea)) * longint'($signed(eb));
            end
            exp_u[r]  = ((acc_in ? exp_u[r] : 0) + su) & 64'hFF_FFFF;
            exp_s[r]  = ((acc_in ? exp_s[r] : 0) + ss) & 64'hFF_FFFF;
            exp_16[r] = ((acc_in ? exp_16[r] : 0) + su) & 64'hFFFF;
        end
    endfunction

    function automatic void fill_const(input logic [AW-1:0] base, input logic [7:0] a,
                                       input bit a_inc, input logic [7:0] b);
        mem[4'(base)] = {COLS{b}};
        for (int r = 0; r < ROWS; r++)
            mem[4'(base + 32'(r) + 32'd1)] = {COLS{a_inc ? 8'(a + 8'(r)) : a}};
    endfunction

    function automatic void fill_rand(input logic [AW-1:0] base);
        for (int r = 0; r <= ROWS; r++)
            mem[4'(base + 32'(r))] = {$urandom, $urandom};
    endfunction

    task automatic check_results();
        for (int r = 0; r < ROWS; r++) begin
            res_sel = 3'(r);
            #1;
            chk($sformatf("res_u[%0d]", r), 64'(res_u), exp_u[r]);
            chk($sformatf("res_s[%0d]", r), 64'(res_s), exp_s[r]);
            chk($sformatf("res_16[%0d]", r), 64'(res_16), exp_16[r]);
        end
    endtask

    int run_no = 0;

    task automatic do_run(input logic [AW-1:0] base, input logic acc_in, input int l,
                          input bit st, input bit glitch, input bit chk_lat);
        int s;
        int w;
        bit seen;
        lat = l;
        stall_en = st;
        acc_addr_q.delete();
        done_cnt = 0;
        model_run(acc_in, base);
        @(negedge clk); #1;
        start = 1'b1; accumulate = acc_in; base_addr = base; s = cyc;
        @(negedge clk); #1;
        start = 1'b0; accumulate = 1'($urandom); base_addr = $urandom;
        w = 1;
        seen = 0;
        while (!seen && w < 2000) begin
            if (done_v[0]) begin
                seen = 1;
            end else begin
                start = glitch && (w == 3 || w == ROWS + l + 5);
                accumulate = 1'b0;
                @(negedge clk); #1;
                w++;
            end
        end
        start = 1'b0;
        chk("done_seen", 64'(seen), 64'd1);
        if (!seen) return;
        chk("busy_at_done", 64'(busy_v[0]), 64'd0);
        chk("done_s", 64'(done_v[1]), 64'd1);
        chk("done_16", 64'(done_v[2]), 64'd1);
        if (chk_lat) chk("latency", 64'(cyc - s), 64'(ROWS + COLS + l + 2));
        // start raised during the DONE cycle must be ignored
        start = 1'b1; accumulate = 1'b0;
        @(negedge clk); #1;
        start = 1'b0;
        chk("done_pulse", 64'(done_v[0]), 64'd0);
        chk("start_in_done", 64'(busy_v[0]), 64'd0);
        @(negedge clk); #1;
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("read_count", 64'(acc_addr_q.size()), 64'(ROWS + 1));
        for (int i = 0; i < acc_addr_q.size() && i <= ROWS; i++)
            chk("read_addr", 64'(acc_addr_q[i]), 64'(base + 32'(i)));
        check_results();
        $display("run %0d: base=%h acc=%0d lat=%0d stall=%0d glitch=%0d row7=%h/%h/%h",
                 run_no, base, acc_in, l, st, glitch, exp_u[7], exp_s[7], exp_16[7]);
        run_no++;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [7:0]  a;
        bit          a_inc;
        logic [7:0]  b;
        logic        acc;
        bit          glitch;
        logic [23:0] exp_u7;
        logic [23:0] exp_s0;
        logic [15:0] exp_16_0;
    } vec_t;

    vec_t tbl [5];

    initial begin
        logic [AW-1:0] base;
        int            dc;

        tbl[0] = '{8'd1,   1, 8'd1,   1'b0, 0, 24'd64,      24'd8,       16'd8};
        tbl[1] = '{8'd1,   1, 8'd1,   1'b1, 1, 24'd128,     24'd16,      16'd16};
        tbl[2] = '{8'd1,   1, 8'd1,   1'b0, 0, 24'd64,      24'd8,       16'd8};
        tbl[3] = '{8'hFF,  0, 8'h02,  1'b0, 0, 24'h000FF0,  24'hFFFFF0,  16'h0FF0};
        tbl[4] = '{8'hFF,  0, 8'hFF,  1'b0, 0, 24'h07F008,  24'h000008,  16'hF008};

        model_clear();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", 64'(busy_v[0]), 64'd0);
        chk("rst_done", 64'(done_v[0]), 64'd0);
        chk("rst_read", 64'(rd_v[0]), 64'd0);
        chk("rst_addr", 64'(addr_v[0]), 64'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_results();

        for (int i = 0; i < 5; i++) begin
            base = $urandom;
            fill_const(base, tbl[i].a, tbl[i].a_inc, tbl[i].b);
            do_run(base, tbl[i].acc, 1, 0, tbl[i].glitch, 1);
            res_sel = 3'd7; #1;
            chk("tbl_u_row7", 64'(res_u), 64'(tbl[i].exp_u7));
            res_sel = 3'd0; #1;
            chk("tbl_s_row0", 64'(res_s), 64'(tbl[i].exp_s0));
            chk("tbl_16_row0", 64'(res_16), 64'(tbl[i].exp_16_0));
        end

        // fixed latency without stalls, latency 5
        base = $urandom;
        fill_rand(base);
        do_run(base, 1'b0, 5, 0, 0, 1);

        // reset while reads are outstanding; the late responses arrive after release
        base = $urandom;
        fill_rand(base);
        lat = 5;
        stall_en = 0;
        @(negedge clk); #1;
        start = 1'b1; accumulate = 1'b0; base_addr = base;
        @(negedge clk); #1;
        start = 1'b0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_v[0]), 64'd0);
        chk("midrst_read", 64'(rd_v[0]), 64'd0);
        chk("midrst_addr", 64'(addr_v[0]), 64'd0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        dc = done_cnt;
        repeat (8) begin
            @(negedge clk); #1;
            chk("post_rst_busy", 64'(busy_v[0]), 64'd0);
            chk("post_rst_read", 64'(rd_v[0]), 64'd0);
        end
        chk("post_rst_no_done", 64'(done_cnt), 64'(dc));
        check_results();
        $display("reset mid-fetch: %0d stray responses pending at release", 3);
        base = $urandom;
        fill_rand(base);
        do_run(base, 1'b1, 2, 0, 0, 1);

        // randomized runs with stalls and varying latency
        for (int i = 0; i < 20; i++) begin
            base = $urandom;
            fill_rand(base);
            do_run(base, 1'($urandom_range(0, 1)), $urandom_range(1, 5), 1, 0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
